// File: rtl/jt10_adpcm_rdrom.sv
// ADPCM-A ROM reader: serves time-multiplexed per-channel nibble requests from a
// one-byte-per-channel cache, refilling it from sample ROM through a req/ok handshake.
module jt10_adpcm_rdrom #(
    parameter int CH     = 6,
    parameter int ROM_AW = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              slot_sync,
    input  logic [19:0]       addr,
    input  logic [3:0]        bank,
    input  logic              sel,
    input  logic              roe_n,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [3:0]        dout,
    output logic [2:0]        dout_slot,
    output logic              dout_vld,
    output logic              miss
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [2:0]  r_slot;
    logic [2:0]  w_reqCh;
    logic [23:0] w_key;
    logic [23:0] w_keyNext;
    logic        w_lookup;
    logic        w_hit;
    logic        w_setPend;
    logic [23:0] w_newPadr;
    logic [7:0]  w_hitByte;

    logic [23:0] r_tag  [CH];
    logic [23:0] r_padr [CH];
    logic [7:0]  r_byte [CH];
    logic [CH-1:0] r_valid;
    logic [CH-1:0] r_pend;

    logic [2:0]  r_idx;
    logic [2:0]  r_rrPtr;
    logic [2:0]  w_pick;
    logic        w_anyPend;
    logic        w_start;
    logic        w_done;
    logic [23:0] r_romAddr;

    logic [3:0]  r_dout;
    logic [2:0]  r_doutSlot;
    logic        r_doutVld;
    logic        r_miss;

    assign w_reqCh   = slot_sync ? 3'd0 : r_slot;
    assign w_key     = {bank, addr};
    // Prefetch stays inside the bank: only the 20-bit address wraps.
    assign w_keyNext = {bank, addr + 20'd1};
    assign w_lookup  = cen & ~roe_n;
    assign w_hitByte = r_byte[w_reqCh];
    assign w_hit     = r_valid[w_reqCh] & (r_tag[w_reqCh] == w_key);
    assign w_setPend = w_lookup & (~w_hit | sel);
    assign w_newPadr = w_hit ? w_keyNext : w_key;

    always_comb begin
        w_pick    = r_rrPtr;
        w_anyPend = 1'b0;
        // Walk offsets downwards so the lowest offset from rr_ptr wins.
        for (int j = CH - 1; j >= 0; j--) begin
            int c;
            c = int'(r_rrPtr) + j;
            if (c >= CH) c = c - CH;
            if (r_pend[c]) begin
                w_pick    = 3'(c);
                w_anyPend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_anyPend) begin
                    w_start     = 1'b1;
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rom_ok) begin
                    w_done      = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= 3'd0;
            r_rrPtr   <= 3'd0;
            r_romAddr <= 24'd0;
        end else begin
            if (w_start) begin
                r_idx     <= w_pick;
                r_romAddr <= r_padr[w_pick];
            end
            if (w_done) begin
                r_rrPtr <= (r_idx == 3'(CH - 1)) ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    // A lookup update in the same clk as fetch completion overrides the pend clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_tag[i]  <= 24'd0;
                r_padr[i] <= 24'd0;
                r_byte[i] <= 8'd0;
            end
            r_valid <= '0;
            r_pend  <= '0;
        end else begin
            if (w_done) begin
                r_byte[r_idx]  <= rom_data;
                r_tag[r_idx]   <= r_romAddr;
                r_valid[r_idx] <= 1'b1;
                if (r_padr[r_idx] == r_romAddr) r_pend[r_idx] <= 1'b0;
            end
            if (w_setPend) begin
                r_padr[w_reqCh] <= w_newPadr;
                r_pend[w_reqCh] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot     <= 3'd0;
            r_dout     <= 4'd0;
            r_doutSlot <= 3'd0;
            r_doutVld  <= 1'b0;
            r_miss     <= 1'b0;
        end else if (cen) begin
            if (slot_sync)                   r_slot <= 3'd1;
            else if (r_slot == 3'(CH - 1))   r_slot <= 3'd0;
            else                             r_slot <= r_slot + 3'd1;
            r_doutVld  <= 1'b1;
            r_doutSlot <= w_reqCh;
            r_miss     <= w_lookup & ~w_hit;
            if (w_lookup & w_hit) r_dout <= sel ? w_hitByte[3:0] : w_hitByte[7:4];
            else                  r_dout <= 4'd0;
        end else begin
            r_doutVld <= 1'b0;
            r_miss    <= 1'b0;
        end
    end

    assign rom_cs    = (r_state == S_WAIT);
    assign rom_addr  = ROM_AW'(r_romAddr);
    assign dout      = r_dout;
    assign dout_slot = r_doutSlot;
    assign dout_vld  = r_doutVld;
    assign miss      = r_miss;

endmodule

// File: tb/tb_jt10_adpcm_rdrom.sv
// Bench for jt10_adpcm_rdrom: behavioural cache/fetch model plus an emulated sample ROM,
// compared against the DUT every clk, with literal expectations for the directed cases.
module tb_jt10_adpcm_rdrom;
    localparam int CH = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cen = 1'b0;
    logic        slot_sync = 1'b0;
    logic [19:0] addr = 20'd0;
    logic [3:0]  bank = 4'd0;
    logic        sel = 1'b0;
    logic        roe_n = 1'b1;
    logic [23:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = 8'd0;
    logic        rom_ok = 1'b0;
    logic [3:0]  dout;
    logic [2:0]  dout_slot;
    logic        dout_vld;
    logic        miss;

    jt10_adpcm_rdrom #(.CH(CH), .ROM_AW(24)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .slot_sync(slot_sync),
        .addr(addr), .bank(bank), .sel(sel), .roe_n(roe_n),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .dout(dout), .dout_slot(dout_slot), .dout_vld(dout_vld), .miss(miss)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    // model state
    logic [23:0] mTag  [CH];
    logic [23:0] mPadr [CH];
    logic [7:0]  mByte [CH];
    bit          mValid[CH];
    bit          mPend [CH];
    int          mSlot, mRr, mIdx;
    bit          mBusy;
    logic [23:0] mAddr;
    int          romCnt, curLat;
    int          romLat = 3;
    bit          expVld, expMiss;
    logic [3:0]  expDout;
    int          expSlot;

    logic [23:0] fetchLog[$];
    logic [3:0]  lastDout[CH];
    logic        lastMiss[CH];

    bit          rqAct [CH];
    logic [3:0]  rqBank[CH];
    logic [19:0] rqAddr[CH];
    logic        rqSel [CH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] romByte(input logic [23:0] a);
        if (a == 24'h300010) return 8'hA5;
        return a[7:0] ^ a[23:16] ^ 8'h69;
    endfunction

    function automatic bit anyPend();
        for (int i = 0; i < CH; i++) if (mPend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            mTag[i] = '0; mPadr[i] = '0; mByte[i] = '0; mValid[i] = 0; mPend[i] = 0;
        end
        mSlot = 0; mRr = 0; mIdx = 0; mBusy = 0; mAddr = '0;
        romCnt = 0; curLat = 0; rom_ok = 1'b0;
    endtask

    // One clk: predict the edge from the model, then compare and drive the ROM side.
    task automatic cycle();
        int          k;
        int          pick;
        bit          hit;
        logic [23:0] key;
        logic [23:0] oldPadr[CH];
        bit          oldPend[CH];
        oldPadr = mPadr;
        oldPend = mPend;
        hit = 0; k = 0; key = {bank, addr};
        expVld = 0; expMiss = 0;
        if (cen) begin
            k = slot_sync ? 0 : mSlot;
            mSlot = slot_sync ? 1 : ((mSlot == CH - 1) ? 0 : mSlot + 1);
            expVld = 1; expSlot = k; expDout = 4'd0;
            if (!roe_n) begin
                hit = mValid[k] && (mTag[k] == key);
                if (hit) expDout = sel ? mByte[k][3:0] : mByte[k][7:4];
                else     expMiss = 1;
            end
        end
        if (mBusy && rom_ok) begin
            mByte[mIdx] = rom_data; mTag[mIdx] = mAddr; mValid[mIdx] = 1;
            if (oldPadr[mIdx] == mAddr) mPend[mIdx] = 0;
            mBusy = 0;
            mRr = (mIdx + 1) % CH;
        end else if (!mBusy) begin
            pick = -1;
            for (int d = 0; d < CH; d++)
                if (pick < 0 && oldPend[(mRr + d) % CH]) pick = (mRr + d) % CH;
            if (pick >= 0) begin
                mBusy = 1; mIdx = pick; mAddr = oldPadr[pick];
                romCnt = 0; curLat = romLat;
                fetchLog.push_back(mAddr);
            end
        end
        if (cen && !roe_n && (!hit || sel)) begin
            mPadr[k] = hit ? {bank, addr + 20'd1} : key;
            mPend[k] = 1;
        end
        @(posedge clk);
        #1;
        checkOutput("dout_vld", dout_vld, expVld);
        checkOutput("miss", miss, expMiss);
        checkOutput("rom_cs", rom_cs, mBusy);
        if (mBusy) checkOutput("rom_addr", rom_addr, mAddr);
        if (expVld) begin
            checkOutput("dout", dout, expDout);
            checkOutput("dout_slot", dout_slot, expSlot);
            lastDout[expSlot] = dout;
            lastMiss[expSlot] = miss;
        end
        rom_ok = 1'b0;
        if (mBusy) begin
            romCnt++;
            if (romCnt >= curLat) begin
                rom_ok   = 1'b1;
                rom_data = romByte(mAddr);
            end
        end
    endtask

    task automatic clearReq();
        for (int i = 0; i < CH; i++) begin
            rqAct[i] = 0; rqBank[i] = 4'd0; rqAddr[i] = 20'd0; rqSel[i] = 1'b0;
        end
    endtask

    task automatic setReq(input int ch, input logic [3:0] b, input logic [19:0] a, input logic s);
        rqAct[ch] = 1; rqBank[ch] = b; rqAddr[ch] = a; rqSel[ch] = s;
    endtask

    // One full slot rotation, cen every 4 clk, slot_sync on slot 0.
    task automatic applyStimulus();
        for (int ch = 0; ch < CH; ch++) begin
            cen = 1'b1; slot_sync = (ch == 0);
            roe_n = !rqAct[ch]; bank = rqBank[ch]; addr = rqAddr[ch]; sel = rqSel[ch];
            cycle();
            cen = 1'b0; slot_sync = 1'b0; roe_n = 1'b1;
            repeat (3) cycle();
        end
        clearReq();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mBusy || anyPend()) && n < 400) begin
            cycle();
            n++;
        end
        checkOutput("drain_bound", n < 400, 1);
    endtask

    initial begin
        modelReset();
        clearReq();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_vld", dout_vld, 0);
        checkOutput("rst_miss", miss, 0);
        checkOutput("rst_cs", rom_cs, 0);
        checkOutput("rst_addr", rom_addr, 0);
        checkOutput("rst_slot", dout_slot, 0);
        rst_n = 1'b1;

        // idle channels
        applyStimulus();
        applyStimulus();

        // cold miss, fill, nibble select, prefetch
        fetchLog.delete();
        setReq(2, 4'h3, 20'h00010, 1'b0);
        applyStimulus();
        checkOutput("t2_miss", lastMiss[2], 1);
        drain();
        checkOutput("t2_fetch0", fetchLog[0], 24'h300010);
        setReq(2, 4'h3, 20'h00010, 1'b0);
        applyStimulus();
        checkOutput("t2_hi", lastDout[2], 4'hA);
        setReq(2, 4'h3, 20'h00010, 1'b1);
        applyStimulus();
        checkOutput("t2_lo", lastDout[2], 4'h5);
        drain();
        checkOutput("t2_prefetch", fetchLog[1], 24'h300011);

        // prefetch wrap inside bank
        fetchLog.delete();
        setReq(0, 4'h1, 20'hFFFFF, 1'b0);
        applyStimulus();
        drain();
        setReq(0, 4'h1, 20'hFFFFF, 1'b0);
        applyStimulus();
        checkOutput("t3_hi", lastDout[0], 4'h8);
        setReq(0, 4'h1, 20'hFFFFF, 1'b1);
        applyStimulus();
        checkOutput("t3_lo", lastDout[0], 4'h9);
        drain();
        checkOutput("t3_wrap", fetchLog[1], 24'h100000);

        // stray rom_ok with no fetch outstanding
        rom_ok = 1'b1;
        cycle();
        cycle();

        // round-robin order behind a slow fetch
        fetchLog.delete();
        romLat = 30;
        setReq(0, 4'h2, 20'h00100, 1'b0);
        setReq(1, 4'h2, 20'h00101, 1'b0);
        setReq(4, 4'h2, 20'h00104, 1'b0);
        setReq(5, 4'h2, 20'h00105, 1'b0);
        applyStimulus();
        drain();
        romLat = 3;
        checkOutput("t4_n", fetchLog.size(), 4);
        checkOutput("t4_f0", fetchLog[0], 24'h200100);
        checkOutput("t4_f1", fetchLog[1], 24'h200101);
        checkOutput("t4_f2", fetchLog[2], 24'h200104);
        checkOutput("t4_f3", fetchLog[3], 24'h200105);

        // retarget while fetch in flight; rom_ok lands on the same clk as the new request
        fetchLog.delete();
        romLat = 23;
        setReq(3, 4'h0, 20'h00020, 1'b0);
        applyStimulus();
        setReq(3, 4'h0, 20'h00040, 1'b0);
        applyStimulus();
        romLat = 3;
        checkOutput("t5_miss", lastMiss[3], 1);
        drain();
        checkOutput("t5_n", fetchLog.size(), 2);
        checkOutput("t5_f0", fetchLog[0], 24'h000020);
        checkOutput("t5_f1", fetchLog[1], 24'h000040);
        setReq(3, 4'h0, 20'h00040, 1'b0);
        applyStimulus();
        checkOutput("t5_hi", lastDout[3], 4'h2);

        // reset during a fetch
        romLat = 60;
        setReq(1, 4'h0, 20'h00077, 1'b0);
        applyStimulus();
        checkOutput("t6_cs_on", rom_cs, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_cs_off", rom_cs, 0);
        checkOutput("t6_vld", dout_vld, 0);
        modelReset();
        romLat = 3;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        setReq(0, 4'h1, 20'hFFFFF, 1'b0);
        setReq(2, 4'h3, 20'h00011, 1'b1);
        applyStimulus();
        checkOutput("t6_miss0", lastMiss[0], 1);
        checkOutput("t6_miss2", lastMiss[2], 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
